// File: rtl/g8ter_sweep_ctrl.sv
// Self-test sequencer for an external greater-than comparator: walks every
// (a, b) operand pair, samples cmp_g after a settle window and checks it against a > b.
module g8ter_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   cmp_a,
    output logic [WIDTH-1:0]   cmp_b,
    input  logic               cmp_g,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int         IW       = 2 * WIDTH;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic [3:0]        hcnt_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [IW:0]       err_q;
    logic              fail_valid_q;
    logic [WIDTH-1:0]  fail_a_q;
    logic [WIDTH-1:0]  fail_b_q;

    logic              sample_s;
    logic              mismatch_s;
    logic              last_s;
    logic [IW:0]       err_count_d;

    // Sample qualification and the error count including the sample taken this edge.
    always_comb begin
        sample_s    = 1'b0;
        mismatch_s  = 1'b0;
        if ((state_q == S_RUN) && !abort && (hcnt_q == SETTLE_C)) begin
            sample_s   = 1'b1;
            mismatch_s = (cmp_g != (idx_q[WIDTH-1:0] > idx_q[IW-1:WIDTH]));
        end else begin
            sample_s   = 1'b0;
            mismatch_s = 1'b0;
        end
        err_count_d = err_q + {{IW{1'b0}}, mismatch_s};
        last_s      = (idx_q == {IW{1'b1}});
    end

    // Sweep FSM; every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= {IW{1'b0}};
            hcnt_q       <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= {(IW+1){1'b0}};
            fail_valid_q <= 1'b0;
            fail_a_q     <= {WIDTH{1'b0}};
            fail_b_q     <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q      <= S_RUN;
                        idx_q        <= {IW{1'b0}};
                        hcnt_q       <= 4'd0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        err_q        <= {(IW+1){1'b0}};
                        fail_valid_q <= 1'b0;
                        fail_a_q     <= {WIDTH{1'b0}};
                        fail_b_q     <= {WIDTH{1'b0}};
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // The sample due on this edge is dropped; partial results stay visible.
                        state_q <= S_IDLE;
                        idx_q   <= {IW{1'b0}};
                        hcnt_q  <= 4'd0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (!sample_s) begin
                        hcnt_q <= hcnt_q + 4'd1;
                    end else begin
                        err_q <= err_count_d;
                        if (mismatch_s && !fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_a_q     <= idx_q[WIDTH-1:0];
                            fail_b_q     <= idx_q[IW-1:WIDTH];
                        end
                        if (last_s) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == {(IW+1){1'b0}});
                        end else begin
                            idx_q  <= idx_q + {{(IW-1){1'b0}}, 1'b1};
                            hcnt_q <= 4'd0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    idx_q   <= {IW{1'b0}};
                    hcnt_q  <= 4'd0;
                    if (abort) begin
                        pass_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    idx_q   <= {IW{1'b0}};
                    hcnt_q  <= 4'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmp_a      = idx_q[WIDTH-1:0];
    assign cmp_b      = idx_q[IW-1:WIDTH];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;

endmodule

// File: tb/tb_g8ter_sweep_ctrl.sv
// Bench for g8ter_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driving behavioural comparator models.
module tb_g8ter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, abort1, start3, abort3;
    logic [3:0] a1, b1, a3, b3, fa1, fb1, fa3, fb3;
    logic       g1, g3;
    logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [8:0] err1, err3;

    int mode = 0;
    int tests = 0;
    int failed = 0;
    logic [7:0] exp_q[$];

    logic d1_1 = 1'b0, d2_1 = 1'b0, d3_1 = 1'b0;
    logic d1_3 = 1'b0, d2_3 = 1'b0, d3_3 = 1'b0;

    always #5 clk = ~clk;

    g8ter_sweep_ctrl #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .cmp_a(a1), .cmp_b(b1), .cmp_g(g1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1));

    g8ter_sweep_ctrl #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .cmp_a(a3), .cmp_b(b3), .cmp_g(g3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3));

    // Three-cycle delayed comparator models
    always @(posedge clk) begin
        d1_1 <= (a1 > b1); d2_1 <= d1_1; d3_1 <= d2_1;
        d1_3 <= (a3 > b3); d2_3 <= d1_3; d3_3 <= d2_3;
    end

    always_comb begin
        case (mode)
            0:       g1 = (a1 > b1);
            1:       g1 = 1'b0;
            2:       g1 = (a1 >= b1);
            default: g1 = d3_1;
        endcase
        g3 = d3_3;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_sweep(input bit use3, input int m, output int busy_n, output int done_n);
        logic [7:0] cur, prev, expv;
        bit first, got;
        mode = m;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        step();
        start1 = 1'b0; start3 = 1'b0;
        busy_n = 0; done_n = 0; first = 1'b1; got = 1'b0; prev = 8'd0;
        for (int c = 0; c < 2400 && !got; c++) begin
            if (use3 ? busy3 : busy1) begin
                busy_n++;
                cur = use3 ? {b3, a3} : {b1, a1};
                if (first || cur != prev) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        failed++;
                        $display("FAIL pair_order: got extra pair %0d, expected none", cur);
                    end else begin
                        expv = exp_q.pop_front();
                        if (cur !== expv) begin
                            failed++;
                            $display("FAIL pair_order: got pair %0d, expected %0d", cur, expv);
                        end
                    end
                end
                prev = cur; first = 1'b0;
            end
            if (use3 ? done3 : done1) begin
                done_n++; got = 1'b1;
            end else begin
                step();
            end
        end
        tests++;
        if (!got || exp_q.size() != 0) begin
            failed++;
            $display("FAIL sweep_end: done seen %0d, pairs left %0d, expected done with 0 left", got, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        repeat (3) step();
        tests++;
        if ({a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1} !== 29'd0 ||
            {a3, b3, busy3, done3, pass3, err3, fv3, fa3, fb3} !== 29'd0) begin
            failed++;
            $display("FAIL reset_state: dut1 %h dut3 %h, expected 0",
                     {a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1},
                     {a3, b3, busy3, done3, pass3, err3, fv3, fa3, fb3});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_correct();
        int bn, dn;
        do_sweep(1'b0, 0, bn, dn);
        tests++;
        if (bn !== 512 || dn !== 1) begin
            failed++; $display("FAIL correct_len: busy %0d done %0d, expected 512 and 1", bn, dn);
        end
        tests++;
        if (err1 !== 9'd0 || pass1 !== 1'b1 || fv1 !== 1'b0) begin
            failed++; $display("FAIL correct_result: err %0d pass %0d fv %0d, expected 0 1 0", err1, pass1, fv1);
        end
        step();
        tests++;
        if (done1 !== 1'b0 || {a1, b1} !== 8'd0 || pass1 !== 1'b1) begin
            failed++; $display("FAIL correct_idle: done %0d ops %h pass %0d, expected 0 00 1", done1, {a1, b1}, pass1);
        end
    endtask

    task automatic test_stuck0();
        int bn, dn;
        do_sweep(1'b0, 1, bn, dn);
        tests++;
        if (err1 !== 9'd120 || pass1 !== 1'b0 || fv1 !== 1'b1 || fa1 !== 4'd1 || fb1 !== 4'd0) begin
            failed++;
            $display("FAIL stuck0: err %0d pass %0d fv %0d fa %0d fb %0d, expected 120 0 1 1 0", err1, pass1, fv1, fa1, fb1);
        end
        step();
    endtask

    task automatic test_ge();
        int bn, dn;
        do_sweep(1'b0, 2, bn, dn);
        tests++;
        if (err1 !== 9'd16 || pass1 !== 1'b0 || fv1 !== 1'b1 || fa1 !== 4'd0 || fb1 !== 4'd0) begin
            failed++;
            $display("FAIL ge_model: err %0d pass %0d fv %0d fa %0d fb %0d, expected 16 0 1 0 0", err1, pass1, fv1, fa1, fb1);
        end
        step();
    endtask

    task automatic test_settle();
        int bn, dn;
        do_sweep(1'b1, 0, bn, dn);
        tests++;
        if (bn !== 1024 || err3 !== 9'd0 || pass3 !== 1'b1) begin
            failed++; $display("FAIL settle3_delayed: busy %0d err %0d pass %0d, expected 1024 0 1", bn, err3, pass3);
        end
        step();
        do_sweep(1'b0, 3, bn, dn);
        tests++;
        if (err1 === 9'd0 || pass1 !== 1'b0) begin
            failed++; $display("FAIL settle1_delayed: err %0d pass %0d, expected nonzero and 0", err1, pass1);
        end
        step();
    endtask

    task automatic test_start_abort_idle();
        mode = 0;
        start1 = 1'b1; abort1 = 1'b1;
        repeat (4) step();
        start1 = 1'b0; abort1 = 1'b0;
        step();
        tests++;
        if (busy1 !== 1'b0 || {a1, b1} !== 8'd0 || done1 !== 1'b0) begin
            failed++; $display("FAIL start_abort_idle: busy %0d ops %h done %0d, expected 0 00 0", busy1, {a1, b1}, done1);
        end
    endtask

    task automatic test_start_busy();
        bit got;
        mode = 0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (50) step();
        start1 = 1'b1;
        repeat (20) step();
        start1 = 1'b0;
        tests++;
        if (busy1 !== 1'b1 || {b1, a1} !== 8'd35) begin
            failed++; $display("FAIL start_while_busy: busy %0d pair %0d, expected 1 35", busy1, {b1, a1});
        end
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            if (done1) got = 1'b1; else step();
        end
        tests++;
        if (!got || err1 !== 9'd0 || pass1 !== 1'b1) begin
            failed++; $display("FAIL start_busy_finish: done %0d err %0d pass %0d, expected 1 0 1", got, err1, pass1);
        end
        step();
    endtask

    task automatic test_abort();
        bit hit, saw_done;
        mode = 1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 600 && !hit; c++) begin
            if ({b1, a1} == 8'd100) hit = 1'b1; else step();
        end
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        tests++;
        if (!hit || busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 || {a1, b1} !== 8'd0) begin
            failed++;
            $display("FAIL abort_state: hit %0d busy %0d done %0d pass %0d ops %h, expected 1 0 0 0 00", hit, busy1, done1, pass1, {a1, b1});
        end
        tests++;
        if (err1 !== 9'd75 || fv1 !== 1'b1 || fa1 !== 4'd1 || fb1 !== 4'd0) begin
            failed++; $display("FAIL abort_partial: err %0d fv %0d fa %0d fb %0d, expected 75 1 1 0", err1, fv1, fa1, fb1);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done1 || busy1) saw_done = 1'b1;
            step();
        end
        tests++;
        if (saw_done !== 1'b0) begin
            failed++; $display("FAIL abort_no_done: activity %0d, expected 0", saw_done);
        end
    endtask

    task automatic test_reset_mid();
        int bn, dn;
        mode = 0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (100) step();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1} !== 29'd0) begin
            failed++; $display("FAIL reset_mid: outputs %h, expected 0", {a1, b1, busy1, done1, pass1, err1, fv1, fa1, fb1});
        end
        step();
        rst_n = 1'b1;
        step();
        do_sweep(1'b0, 0, bn, dn);
        tests++;
        if (bn !== 512 || dn !== 1 || err1 !== 9'd0 || pass1 !== 1'b1) begin
            failed++; $display("FAIL reset_restart: busy %0d done %0d err %0d pass %0d, expected 512 1 0 1", bn, dn, err1, pass1);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck0();
        test_ge();
        test_settle();
        test_start_abort_idle();
        test_start_busy();
        test_abort();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/g8ter_sweep_ctrl.md
# g8ter_sweep_ctrl

Self-test sequencer for the 4-bit greater-than comparator datapath, intended for on-board use on the Elbert V2.
- Drives every (a, b) operand pair into an external comparator instance.
- Samples its g output after a programmable settle time and checks it against an internal golden a > b.
- Reports error count, first failing pair and pass/fail through a start/done handshake.

## Interface

Parameters:
- WIDTH, 4, operand width; sweep covers 2^(2*WIDTH) pairs
- SETTLE, 1, extra cycles each pair is held before sampling (legal 0..15)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled request to begin a sweep (honoured only in IDLE)
- abort  in  1  terminate the sweep in progress
- cmp_a  out  WIDTH  operand a to the comparator under test (registered)
- cmp_b  out  WIDTH  operand b to the comparator under test (registered)
- cmp_g  in  1  comparator result, expected 1 iff cmp_a > cmp_b (unsigned)
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse when a sweep completes normally
- pass  out  1  1 iff last completed sweep had zero errors; held until next start
- err_count  out  2*WIDTH+1  mismatches in current/last sweep (max 256 for WIDTH=4, no saturation needed)
- fail_valid  out  1  at least one mismatch recorded
- fail_a  out  WIDTH  cmp_a of first mismatch
- fail_b  out  WIDTH  cmp_b of first mismatch

## Operation

- States: IDLE, RUN, DONE.
- Internal index idx, 2*WIDTH bits, with cmp_a = idx[WIDTH-1:0] and cmp_b = idx[2*WIDTH-1:WIDTH]. a increments fastest, b after every a wrap.
- Internal hold counter hcnt, 4 bits.
- IDLE -> RUN when start=1 and abort=0 at an edge. On that edge:
  - idx=0, hcnt=0, busy=1.
  - err_count=0, fail_valid=0, fail_a=0, fail_b=0, pass=0.
- RUN, each edge:
  - If hcnt != SETTLE: hcnt++.
  - Else sample cmp_g and compare against (cmp_a > cmp_b). On mismatch, err_count++; if fail_valid=0, also latch fail_a/fail_b from the current operands and set fail_valid=1.
  - Then, if idx is all-ones, go to DONE. Otherwise idx++, hcnt=0.
- DONE, one cycle:
  - done=1, busy=0, pass=(err_count==0).
  - Next edge -> IDLE; done=0.
- start while busy or in DONE: ignored.
- abort=1 in RUN or DONE: next edge -> IDLE.
  - busy=0, no done pulse; an abort in DONE cancels the pending pulse.
  - pass=0; err_count and fail_* keep their partial values.
  - The sample due on the aborting edge is discarded.
- abort and start both high in IDLE: abort wins, stay IDLE.
- cmp_a/cmp_b return to 0 on entry to IDLE.
- SETTLE outside 0..15: unsupported.

## Timing

- Reset (async, immediate on rst_n low):
  - State=IDLE.
  - cmp_a=0, cmp_b=0, busy=0, done=0, pass=0.
  - err_count=0, fail_valid=0, fail_a=0, fail_b=0.
- Reset asserted mid-sweep aborts with all of the above cleared. No done pulse.
- Operands are registered and held stable for exactly SETTLE+1 cycles per pair.
- cmp_g is sampled on the last edge of each hold window. The comparator path must settle within SETTLE+1 clock periods.
- Let start be accepted at edge k:
  - Pair n is driven from edge k+n*(SETTLE+1).
  - The last pair (255 for WIDTH=4) is sampled at edge k+256*(SETTLE+1).
  - done is high for the cycle following that edge.
  - err_count includes the final sample in that same cycle.
- Sweep length, edge of start acceptance to done high: 256*(SETTLE+1) cycles. Example: SETTLE=1 gives 512.
- Minimum restart: start may be accepted on the second edge after done, once back in IDLE.

## Test plan

- Correct comparator model, SETTLE=1, start pulse:
  - busy high for 512 cycles, done pulses once.
  - err_count=0, pass=1, fail_valid=0.
  - cmp_a/cmp_b step 0..15 / 0..15, a fastest.
- Comparator with g stuck at 0:
  - err_count=120, pass=0, fail_valid=1.
  - fail_a=1, fail_b=0.
- Comparator computing a >= b:
  - err_count=16, pass=0.
  - fail_a=0, fail_b=0.
- SETTLE=3 with a model whose g is delayed 3 cycles: err_count=0. Same model with SETTLE=1: err_count>0.
- Protocol corner cases:
  - start re-asserted while busy: no restart; idx continues.
  - abort at pair 100 (cmp_b=6, cmp_a=4): busy=0 next edge, no done, pass=0.
  - start and abort together in IDLE: stays IDLE.
- rst_n low for 1 cycle mid-sweep:
  - All outputs go to reset values immediately, with no done pulse.
  - A new start after release runs a full 512-cycle sweep.
